// File: rtl/bus_pkg.sv
// Shared bus definitions: control codes and control-bit positions used by the
// CPU bus interface and by bus_responder.
package bus_pkg;

  localparam logic [3:0] CTL_IDLE   = 4'b0000;
  localparam logic [3:0] CTL_MEM_RD = 4'b0001;
  localparam logic [3:0] CTL_MEM_WR = 4'b0011;
  localparam logic [3:0] CTL_GP_WR  = 4'b0100;
  localparam logic [3:0] CTL_GP_RD  = 4'b1100;
  localparam logic [3:0] CTL_HOLD   = 4'b1111;

  localparam int BIT_EN  = 0;
  localparam int BIT_WE  = 1;
  localparam int BIT_GP  = 2;
  localparam int BIT_TRI = 3;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, 32-bit words, registered read data.
// rdata only changes on a read, so it holds across writes and idle cycles.
module sp_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Target end of the CPU memory/GP bus: RAM and GP register access, error count,
// GP-input IRQ. Optional macro BUS_RESPONDER_IRQ_EN enables the edge detector/irq.
module bus_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int GP_W   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     address_from_cpu,
  input  logic [31:0]     data_from_cpu,
  input  logic [3:0]      control_from_cpu,
  output logic [31:0]     data_to_bus,
  input  logic [GP_W-1:0] gp_in,
  output logic [GP_W-1:0] gp_out,
  output logic            irq,
  output logic [7:0]      err_count
);

  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              ram_en;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic              bad;
  logic              sel_ram;
  logic [31:0]       out_q;
  logic [GP_W-1:0]   gp_s1;
  logic [GP_W-1:0]   gp_s2;
  logic              unused_bits;

  assign unused_bits = &{1'b0, address_from_cpu[1:0]};
  assign in_range    = (address_from_cpu[31:ADDR_W+2] == '0);
  assign idx         = address_from_cpu[ADDR_W+1:2];
  assign ram_en      = in_range && (control_from_cpu == CTL_MEM_RD ||
                                    control_from_cpu == CTL_MEM_WR);
  assign ram_we      = control_from_cpu[BIT_WE];

  sp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx),
    .wdata (data_from_cpu),
    .rdata (ram_rdata)
  );

  always_comb begin
    bad = 1'b0;
    case (control_from_cpu)
      CTL_IDLE, CTL_GP_WR, CTL_GP_RD, CTL_HOLD: bad = 1'b0;
      CTL_MEM_RD, CTL_MEM_WR:                   bad = !in_range;
      default:                                  bad = 1'b1;
    endcase
  end

  // RAM data is already registered inside sp_ram; sel_ram picks it over out_q.
  assign data_to_bus = sel_ram ? ram_rdata : out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_ram   <= 1'b0;
      out_q     <= '0;
      gp_out    <= '0;
      err_count <= '0;
      gp_s1     <= '0;
      gp_s2     <= '0;
    end else begin
      gp_s1 <= gp_in;
      gp_s2 <= gp_s1;
      case (control_from_cpu)
        CTL_MEM_RD: begin
          sel_ram <= in_range;
          out_q   <= '0;
        end
        CTL_GP_WR: gp_out <= data_from_cpu[GP_W-1:0];
        CTL_GP_RD: begin
          sel_ram <= 1'b0;
          out_q   <= 32'(gp_s2);
        end
        default: ;
      endcase
      if (bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

`ifdef BUS_RESPONDER_IRQ_EN
  logic gp_s3;

  // A new edge beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gp_s3 <= 1'b0;
      irq   <= 1'b0;
    end else begin
      gp_s3 <= gp_s2[0];
      if (gp_s2[0] && !gp_s3)               irq <= 1'b1;
      else if (control_from_cpu == CTL_GP_RD) irq <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: RAM access, range errors,
// GP path, irq handshake, error saturation and asynchronous reset.
module tb_bus_responder;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_from_cpu;
  logic [31:0] data_from_cpu;
  logic [3:0]  control_from_cpu;
  logic [31:0] data_to_bus;
  logic [31:0] gp_in;
  logic [31:0] gp_out;
  logic        irq;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  bus_responder dut (
    .clk              (clk),
    .reset            (reset),
    .address_from_cpu (address_from_cpu),
    .data_from_cpu    (data_from_cpu),
    .control_from_cpu (control_from_cpu),
    .data_to_bus      (data_to_bus),
    .gp_in            (gp_in),
    .gp_out           (gp_out),
    .irq              (irq),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [3:0] ctl, input logic [31:0] addr, input logic [31:0] data);
    control_from_cpu = ctl;
    address_from_cpu = addr;
    data_from_cpu    = data;
  endtask

  logic exp_irq_on;

  initial begin
`ifdef BUS_RESPONDER_IRQ_EN
    exp_irq_on = 1'b1;
`else
    exp_irq_on = 1'b0;
`endif
    reset = 1'b1;
    gp_in = '0;
    cmd(CTL_IDLE, '0, '0);
    tick(2);
    check("rst_data", data_to_bus, 32'h0);
    check("rst_gp_out", gp_out, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_err", {24'b0, err_count}, 32'h0);
    reset = 1'b0;
    tick();

    // write then read-back next cycle
    cmd(CTL_MEM_WR, 32'h8, 32'hDEADBEEF);
    tick();
    cmd(CTL_MEM_RD, 32'h8, 32'h0);
    tick();
    check("rd_after_wr", data_to_bus, 32'hDEADBEEF);
    check("err_zero", {24'b0, err_count}, 32'h0);
    cmd(CTL_IDLE, 32'h0, 32'h0);
    tick(2);
    check("idle_hold", data_to_bus, 32'hDEADBEEF);

    // out-of-range write must not alias onto word 3
    cmd(CTL_MEM_WR, 32'hC, 32'h11111111);
    tick();
    check("wr_hold", data_to_bus, 32'hDEADBEEF);
    cmd(CTL_MEM_WR, 32'h100C, 32'h12345678);
    tick();
    check("oor_wr_err", {24'b0, err_count}, 32'h1);
    cmd(CTL_MEM_RD, 32'h100C, 32'h0);
    tick();
    check("oor_rd_zero", data_to_bus, 32'h0);
    check("oor_rd_err", {24'b0, err_count}, 32'h2);
    cmd(CTL_MEM_RD, 32'hF, 32'h0);
    tick();
    check("no_alias", data_to_bus, 32'h11111111);

    // GP write / read
    cmd(CTL_GP_WR, 32'h0, 32'h000000A5);
    tick();
    check("gp_out", gp_out, 32'h000000A5);
    check("gp_wr_hold", data_to_bus, 32'h11111111);
    cmd(CTL_IDLE, 32'h0, 32'h0);
    gp_in = 32'h3C;
    tick(2);
    cmd(CTL_GP_RD, 32'h0, 32'h0);
    tick();
    check("gp_rd", data_to_bus, 32'h0000003C);
    cmd(CTL_HOLD, 32'h0, 32'h0);
    tick();
    check("hold", data_to_bus, 32'h0000003C);
    check("hold_err", {24'b0, err_count}, 32'h2);
    gp_in = 32'h5A;
    cmd(CTL_GP_RD, 32'h0, 32'h0);
    tick(2);
    check("gp_sync_lat2", data_to_bus, 32'h0000003C);
    tick();
    check("gp_sync_lat3", data_to_bus, 32'h0000005A);

    // irq: rising gp_in[0], then clear
    cmd(CTL_IDLE, 32'h0, 32'h0);
    gp_in = 32'h1;
    tick(2);
    check("irq_early", {31'b0, irq}, 32'h0);
    tick();
    check("irq_set", {31'b0, irq}, {31'b0, exp_irq_on});
    cmd(CTL_GP_RD, 32'h0, 32'h0);
    tick();
    check("irq_clr", {31'b0, irq}, 32'h0);
    cmd(CTL_IDLE, 32'h0, 32'h0);
    gp_in = 32'h0;
    tick(3);
    check("irq_fall", {31'b0, irq}, 32'h0);
    gp_in = 32'h1;
    tick(2);
    cmd(CTL_GP_RD, 32'h0, 32'h0);
    tick();
    check("irq_set_wins", {31'b0, irq}, {31'b0, exp_irq_on});
    check("gp_rd_one", data_to_bus, 32'h1);

    // illegal code saturates the error counter
    cmd(4'b0110, 32'h0, 32'h0);
    tick(252);
    check("err_254", {24'b0, err_count}, 32'd254);
    tick();
    check("err_255", {24'b0, err_count}, 32'd255);
    tick(47);
    check("err_sat", {24'b0, err_count}, 32'd255);
    check("illegal_hold", data_to_bus, 32'h1);

    // asynchronous reset mid-stream
    #2;
    reset = 1'b1;
    #1;
    check("arst_data", data_to_bus, 32'h0);
    check("arst_gp_out", gp_out, 32'h0);
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_err", {24'b0, err_count}, 32'h0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
